// File: rtl/num_seq_pkg.sv
// Shared types and sizing for the num symbol-stream player.
package num_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam int SYM_W_DEF = 2;
  localparam int DEPTH_DEF = 16;
  localparam int CNT_W_DEF = $clog2(DEPTH_DEF) + 1;

  // Count needs one more bit than the pointer so a full buffer is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/num_seq_buf.sv
// Symbol store: append-only write port with saturating count, registered read port.
module num_seq_buf
  import num_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SYM_W = SYM_W_DEF,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [SYM_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [SYM_W-1:0] rd_data,
  output logic [CW-1:0]    count
);

  logic [SYM_W-1:0] mem [DEPTH];
  logic             wr_ok;

  // clear wins over a same-cycle write; writes past capacity are dropped.
  assign wr_ok = wr_en && !clear && (count < CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (wr_ok) begin
      count <= count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[count[AW-1:0]] <= wr_data;
    end
  end

  // Read data returns to zero whenever no symbol is being issued.
  always_ff @(posedge clk) begin
    if (reset || !rd_en) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/num_seq_player.sv
// Replays a loaded symbol pattern onto num/num_valid, once or looping.
module num_seq_player
  import num_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SYM_W = SYM_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [SYM_W-1:0]          wr_data,
  input  logic                      start,
  input  logic                      loop,
  input  logic                      stop,
  output logic [SYM_W-1:0]          num,
  output logic                      num_valid,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  // Stream semantics: num_valid qualifies num for exactly one cycle; there is
  // no backpressure, so the consumer must take every valid symbol as it comes.

  state_t        state, state_nx;
  logic [AW-1:0] rd_ptr, rd_ptr_nx;
  logic [AW-1:0] rd_addr;
  logic          issue, done_nx;
  logic          start_ok, buf_clr, buf_wr;

  num_seq_buf #(
    .DEPTH (DEPTH),
    .SYM_W (SYM_W),
    .AW    (AW),
    .CW    (CW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clear   (buf_clr),
    .wr_en   (buf_wr),
    .wr_data (wr_data),
    .rd_en   (issue),
    .rd_addr (rd_addr),
    .rd_data (num),
    .count   (count)
  );

  always_comb begin
    state_nx  = state;
    rd_ptr_nx = rd_ptr;
    rd_addr   = rd_ptr;
    issue     = 1'b0;
    done_nx   = 1'b0;
    start_ok  = 1'b0;
    buf_clr   = 1'b0;
    buf_wr    = 1'b0;

    case (state)
      IDLE: begin
        buf_clr  = clear;
        start_ok = start && !clear && (count != '0);
        buf_wr   = wr_en && !clear && !start_ok;
        if (start_ok) begin
          issue    = 1'b1;
          rd_addr  = '0;
          state_nx = PLAY;
        end
      end
      PLAY: begin
        // A raised done means the final one-shot symbol is on the output now.
        if (stop || done) begin
          state_nx  = IDLE;
          rd_ptr_nx = '0;
        end else begin
          issue = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (issue) begin
      if ({1'b0, rd_addr} == count - CW'(1)) begin
        rd_ptr_nx = '0;
        done_nx   = !loop;
      end else begin
        rd_ptr_nx = rd_addr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      done      <= 1'b0;
      num_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      rd_ptr    <= rd_ptr_nx;
      done      <= done_nx;
      num_valid <= issue;
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = (state == PLAY);

endmodule
